// File: rtl/west_feeder_pkg.sv
// west_feeder shared definitions
// Lane instruction codes and FSM states.
package west_feeder_pkg;

  localparam int INST_W = 2;

  localparam logic [INST_W-1:0] INST_IDLE = 2'b00;
  localparam logic [INST_W-1:0] INST_LOAD = 2'b01;
  localparam logic [INST_W-1:0] INST_EXEC = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_EXEC,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/west_feeder_skew_chain.sv
// west_feeder per-lane delay line
// Delays one lane word (data + inst) by DEPTH cycles.
module west_feeder_skew_chain #(
  parameter int W     = 6,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sh_q [DEPTH];

  // shift register; bubbles move exactly like data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sh_q[i] <= '0;
    end else begin
      sh_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sh_q[i] <= sh_q[i-1];
    end
  end

  assign q_o = sh_q[DEPTH-1];

endmodule

// File: rtl/west_feeder.sv
// west_feeder: west-edge driver of the MAC tile array
// FIFO-buffered vectors, load/exec sequencing, per-row skew.
module west_feeder
  import west_feeder_pkg::*;
#(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int depth  = 16,
  parameter int len_bw = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [row*bw-1:0]   in_vec,
  output logic                full,
  output logic                empty,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [len_bw-1:0]   len,
  output logic [row*bw-1:0]   out_w,
  output logic [row*2-1:0]    inst_w,
  output logic                busy,
  output logic                done
);

  localparam int AW  = $clog2(depth);
  localparam int CW  = AW + 1;
  localparam int LCW = $clog2(col + 1);
  localparam int DCW = $clog2(row) + 1;

  localparam logic [CW-1:0]  CNT_FULL = CW'(depth);
  localparam logic [LCW-1:0] LD_LAST  = LCW'(col - 1);
  localparam logic [DCW-1:0] DR_LAST  = DCW'(row >= 2 ? row - 2 : 0);
  localparam logic           DONE_NOW = (row == 1);

  // FIFO state
  logic [row*bw-1:0] mem_q [depth];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              full_q;
  logic              empty_q;
  logic              push;
  logic              pop;
  logic [row*bw-1:0] rdata;

  // FSM state
  state_e            state_q;
  logic              exec_q;
  logic [len_bw-1:0] len_q;
  logic [LCW-1:0]    ld_cnt_q;
  logic [len_bw-1:0] ex_cnt_q;
  logic [DCW-1:0]    dr_cnt_q;
  logic              done_q;

  // stage-0 issue word
  logic [row*bw-1:0] s0_data_q;
  logic [1:0]        s0_inst_q;

  // pop only while issuing; a push into a full FIFO
  // is still accepted if a pop frees a slot
  always_comb begin
    pop   = 1'b0;
    push  = 1'b0;
    cnt_d = cnt_q;
    rdata = mem_q[rptr_q];
    pop   = (state_q == S_LOAD || state_q == S_EXEC)
            && !empty_q;
    push  = wr && (!full_q || pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // FIFO pointers, count and registered flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_FULL);
      empty_q <= (cnt_d == '0);
    end
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_vec;
  end

  // command sequencer: IDLE/LOAD/GAP/EXEC/DRAIN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      exec_q   <= 1'b0;
      len_q    <= '0;
      ld_cnt_q <= '0;
      ex_cnt_q <= '0;
      dr_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && op != 2'b00) begin
            exec_q   <= op[1];
            len_q    <= len;
            ld_cnt_q <= '0;
            ex_cnt_q <= '0;
            if (op[0]) begin
              state_q <= S_LOAD;
            end else if (op[1] && len != '0) begin
              state_q <= S_EXEC;
            end else begin
              state_q  <= S_DRAIN;
              dr_cnt_q <= '0;
              done_q   <= DONE_NOW;
            end
          end
        end
        S_LOAD: begin
          if (pop) begin
            ld_cnt_q <= ld_cnt_q + 1'b1;
            if (ld_cnt_q == LD_LAST) begin
              if (exec_q && len_q != '0) begin
                state_q <= S_GAP;
              end else begin
                state_q  <= S_DRAIN;
                dr_cnt_q <= '0;
                done_q   <= DONE_NOW;
              end
            end
          end
        end
        S_GAP: begin
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (pop) begin
            ex_cnt_q <= ex_cnt_q + 1'b1;
            if (ex_cnt_q + 1'b1 == len_q) begin
              state_q  <= S_DRAIN;
              dr_cnt_q <= '0;
              done_q   <= DONE_NOW;
            end
          end
        end
        S_DRAIN: begin
          if (done_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else begin
            dr_cnt_q <= dr_cnt_q + 1'b1;
            done_q   <= (dr_cnt_q == DR_LAST);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // stage-0 word: popped vector or a zero bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_data_q <= '0;
      s0_inst_q <= INST_IDLE;
    end else if (pop) begin
      s0_data_q <= rdata;
      s0_inst_q <= (state_q == S_EXEC) ? INST_EXEC
                                       : INST_LOAD;
    end else begin
      s0_data_q <= '0;
      s0_inst_q <= INST_IDLE;
    end
  end

  for (genvar r = 0; r < row; r++) begin : g_lane
    logic [bw+1:0] lane_d;
    logic [bw+1:0] lane_q;

    assign lane_d = {s0_inst_q, s0_data_q[r*bw +: bw]};

    if (r == 0) begin : g_direct
      assign lane_q = lane_d;
    end else begin : g_skew
      west_feeder_skew_chain #(
        .W     (bw + 2),
        .DEPTH (r)
      ) u_chain (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (lane_d),
        .q_o   (lane_q)
      );
    end

    assign out_w[r*bw +: bw]         = lane_q[bw-1:0];
    assign inst_w[r*INST_W +: INST_W] = lane_q[bw+1:bw];
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_west_feeder.sv
// tb_west_feeder: directed checks of west_feeder
// Expected lane words come from per-cycle stage-0 tables.
module tb_west_feeder;

  localparam int BW    = 4;
  localparam int ROW   = 8;
  localparam int COL   = 8;
  localparam int DEPTH = 16;
  localparam int LBW   = 8;
  localparam int NT    = 40;

  logic               clk;
  logic               reset;
  logic               wr;
  logic [ROW*BW-1:0]  in_vec;
  logic               full;
  logic               empty;
  logic               start;
  logic [1:0]         op;
  logic [LBW-1:0]     len;
  logic [ROW*BW-1:0]  out_w;
  logic [ROW*2-1:0]   inst_w;
  logic               busy;
  logic               done;

  int errors = 0;
  int checks = 0;

  logic [ROW*BW-1:0] s0d   [NT];
  logic [1:0]        s0i   [NT];
  logic              wsch  [NT];
  logic [ROW*BW-1:0] wdat  [NT];
  logic              ssch  [NT];
  logic [1:0]        sop   [NT];
  int                efull [NT];

  west_feeder #(
    .bw     (BW),
    .row    (ROW),
    .col    (COL),
    .depth  (DEPTH),
    .len_bw (LBW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .in_vec (in_vec),
    .full   (full),
    .empty  (empty),
    .start  (start),
    .op     (op),
    .len    (len),
    .out_w  (out_w),
    .inst_w (inst_w),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  function automatic logic [ROW*BW-1:0] mkv(input int v);
    logic [ROW*BW-1:0] res;
    res = '0;
    for (int r = 0; r < ROW; r++)
      res[r*BW +: BW] = BW'(v + r + 1);
    return res;
  endfunction

  task automatic clr;
    for (int i = 0; i < NT; i++) begin
      s0d[i]   = '0;
      s0i[i]   = 2'b00;
      wsch[i]  = 1'b0;
      wdat[i]  = '0;
      ssch[i]  = 1'b0;
      sop[i]   = 2'b00;
      efull[i] = -1;
    end
  endtask

  task automatic iss(input int t,
                     input logic [ROW*BW-1:0] d,
                     input logic [1:0] i);
    s0d[t] = d;
    s0i[t] = i;
  endtask

  task automatic push(input logic [ROW*BW-1:0] d);
    wr     = 1'b1;
    in_vec = d;
    tick();
    wr     = 1'b0;
    in_vec = '0;
  endtask

  task automatic cmd(input logic [1:0] o,
                     input logic [LBW-1:0] l);
    start = 1'b1;
    op    = o;
    len   = l;
    tick();
    start = 1'b0;
    op    = 2'b00;
  endtask

  // t=0 is the first cycle after the start edge
  task automatic run(input int ncyc, input int done_t);
    logic [ROW*BW-1:0] ew;
    logic [ROW*2-1:0]  ei;
    for (int t = 0; t < ncyc; t++) begin
      ew = '0;
      ei = '0;
      for (int r = 0; r < ROW; r++) begin
        if (t - r >= 0) begin
          ew[r*BW +: BW] = s0d[t-r][r*BW +: BW];
          ei[r*2 +: 2]   = s0i[t-r];
        end
      end
      chk($sformatf("out_w t=%0d", t), 64'(out_w), 64'(ew));
      chk($sformatf("inst_w t=%0d", t), 64'(inst_w), 64'(ei));
      chk($sformatf("done t=%0d", t), 64'(done),
          64'(t == done_t));
      chk($sformatf("busy t=%0d", t), 64'(busy),
          64'(t <= done_t));
      if (efull[t] >= 0)
        chk($sformatf("full t=%0d", t), 64'(full),
            64'(efull[t]));
      wr     = wsch[t];
      in_vec = wdat[t];
      start  = ssch[t];
      op     = sop[t];
      tick();
    end
    wr     = 1'b0;
    in_vec = '0;
    start  = 1'b0;
    op     = 2'b00;
  endtask

  task automatic load_only_case;
    for (int v = 0; v < 8; v++) push(mkv(v));
    chk("empty before load", 64'(empty), 64'(0));
    clr();
    for (int k = 0; k < 8; k++) iss(k + 1, mkv(k), 2'b01);
    cmd(2'b01, 8'd0);
    run(18, 15);
    chk("empty after load", 64'(empty), 64'(1));
  endtask

  initial begin
    reset  = 1'b1;
    wr     = 1'b0;
    in_vec = '0;
    start  = 1'b0;
    op     = 2'b00;
    len    = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst out_w",  64'(out_w),  64'(0));
    chk("rst inst_w", 64'(inst_w), 64'(0));
    chk("rst full",   64'(full),   64'(0));
    chk("rst empty",  64'(empty),  64'(1));
    chk("rst busy",   64'(busy),   64'(0));
    chk("rst done",   64'(done),   64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // load-only: 8 vectors, skewed by lane
    load_only_case();

    // load then exec from a full FIFO
    for (int v = 0; v < 16; v++) push(mkv(v));
    chk("full preload", 64'(full), 64'(1));
    clr();
    for (int k = 0; k < 8; k++) iss(k + 1, mkv(k), 2'b01);
    for (int k = 0; k < 8; k++) iss(k + 10, mkv(k + 8), 2'b10);
    cmd(2'b11, 8'd8);
    run(27, 24);
    chk("empty after l+e", 64'(empty), 64'(1));

    // exec from a trickling FIFO: bubbles between beats
    clr();
    for (int k = 0; k < 4; k++) begin
      wsch[3*k] = 1'b1;
      wdat[3*k] = mkv(k + 8);
      iss(3*k + 2, mkv(k + 8), 2'b10);
    end
    cmd(2'b10, 8'd4);
    run(21, 18);

    // full FIFO: lone push dropped, push with pop kept
    for (int v = 0; v < 16; v++) push(mkv(v));
    chk("full 16", 64'(full), 64'(1));
    push(32'hA5A5_A5A5);
    chk("full after drop", 64'(full), 64'(1));
    clr();
    wsch[0]  = 1'b1;
    wdat[0]  = 32'h3C3C_3C3C;
    efull[0] = 1;
    efull[1] = 1;
    efull[2] = 0;
    for (int k = 0; k < 16; k++) iss(k + 1, mkv(k), 2'b10);
    iss(17, 32'h3C3C_3C3C, 2'b10);
    cmd(2'b10, 8'd17);
    run(27, 24);

    // op=00 ignored
    cmd(2'b00, 8'd5);
    chk("op00 busy", 64'(busy), 64'(0));
    tick();
    chk("op00 busy2", 64'(busy), 64'(0));
    chk("op00 done", 64'(done), 64'(0));

    // exec with len=0 drains; start while busy ignored
    clr();
    ssch[2] = 1'b1;
    sop[2]  = 2'b01;
    cmd(2'b10, 8'd0);
    run(12, 7);

    // reset in the middle of exec
    for (int v = 0; v < 4; v++) push(mkv(v + 3));
    clr();
    for (int k = 0; k < 4; k++) iss(k + 1, mkv(k + 3), 2'b10);
    cmd(2'b10, 8'd4);
    run(2, 99);
    #2 reset = 1'b0;
    #1;
    chk("mid rst out_w",  64'(out_w),  64'(0));
    chk("mid rst inst_w", 64'(inst_w), 64'(0));
    chk("mid rst empty",  64'(empty),  64'(1));
    chk("mid rst full",   64'(full),   64'(0));
    chk("mid rst busy",   64'(busy),   64'(0));
    chk("mid rst done",   64'(done),   64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // normal load command after the reset
    load_only_case();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
